// File: rtl/screenchar_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : screenchar_write_arbiter
// Description : Round-robin arbiter that lets four requesters (velocity,
//               angle, target, terminal) take turns writing characters into
//               screenchar_mem. The owner keeps the grant for a burst of up
//               to MAX_BURST transfers. Every release is followed by one
//               cycle with no grant.
// Revision    : 1.0 - initial release
// ============================================================================
module screenchar_write_arbiter #(
  parameter int MAX_BURST = 32,
  parameter int ADDR_W    = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   req_index,
  input  logic [31:0]           req_data,
  output logic [3:0]            gnt,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_address,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic [1:0]            last_owner
);

  localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_gnt;
  logic [3:0]          w_gnt_next;
  logic [7:0]          r_burst;
  logic [7:0]          w_burst_next;
  logic [7:0]          w_burst_inc;
  logic [1:0]          r_last_owner;
  logic [1:0]          w_last_owner_next;
  logic                r_wr_en;
  logic                w_wr_en_next;
  logic [ADDR_W-1:0]   r_wr_address;
  logic [ADDR_W-1:0]   w_wr_address_next;
  logic [7:0]          r_wr_data;
  logic [7:0]          w_wr_data_next;

  logic [1:0]          w_winner;
  logic [1:0]          w_cand;
  logic                w_found;
  logic                w_transfer;
  logic [ADDR_W-1:0]   w_sel_index;
  logic [7:0]          w_sel_data;

  // Round-robin search. It starts one past the previous owner, so the
  // previous owner is checked last (i=4 wraps back onto it).
  always_comb begin
    w_winner = r_last_owner;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int i = 1; i <= 4; i++) begin
      w_cand = r_last_owner + 2'(i);
      if (!w_found && req[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  // Select the current owner's address and character. The owner is always last_owner.
  always_comb begin
    w_sel_index = '0;
    w_sel_data  = '0;
    for (int k = 0; k < 4; k++) begin
      if (r_last_owner == 2'(k)) begin
        w_sel_index = req_index[k*ADDR_W +: ADDR_W];
        w_sel_data  = req_data[k*8 +: 8];
      end
    end
  end

  // A transfer happens in any cycle where the granted requester still requests.
  assign w_transfer  = (r_state == ST_GRANT) && (|(r_gnt & req));
  assign w_burst_inc = r_burst + 8'd1;

  // Next-state logic: arbitrate in IDLE; in GRANT, count transfers and release.
  always_comb begin
    w_state_next      = r_state;
    w_gnt_next        = r_gnt;
    w_burst_next      = r_burst;
    w_last_owner_next = r_last_owner;
    w_wr_en_next      = 1'b0;
    w_wr_address_next = r_wr_address;
    w_wr_data_next    = r_wr_data;
    case (r_state)
      ST_IDLE: begin
        w_gnt_next = 4'b0000;
        if (w_found) begin
          w_state_next      = ST_GRANT;
          w_gnt_next        = 4'b0001 << w_winner;
          w_last_owner_next = w_winner;
          w_burst_next      = 8'd0;
        end
      end
      ST_GRANT: begin
        if (w_transfer) begin
          w_wr_en_next      = 1'b1;
          w_wr_address_next = w_sel_index;
          w_wr_data_next    = w_sel_data;
          w_burst_next      = w_burst_inc;
          // The burst limit ends the grant even if the owner keeps requesting.
          if (w_burst_inc == C_MAX_BURST) begin
            w_gnt_next   = 4'b0000;
            w_state_next = ST_IDLE;
          end
        end else begin
          w_gnt_next   = 4'b0000;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_gnt_next   = 4'b0000;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register. Reset puts last_owner at 3 so requester 0 wins first, and it aborts any pending write.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_gnt        <= 4'b0000;
      r_burst      <= 8'd0;
      r_last_owner <= 2'd3;
      r_wr_en      <= 1'b0;
      r_wr_address <= '0;
      r_wr_data    <= 8'd0;
    end else begin
      r_state      <= w_state_next;
      r_gnt        <= w_gnt_next;
      r_burst      <= w_burst_next;
      r_last_owner <= w_last_owner_next;
      r_wr_en      <= w_wr_en_next;
      r_wr_address <= w_wr_address_next;
      r_wr_data    <= w_wr_data_next;
    end
  end

  assign gnt        = r_gnt;
  assign wr_en      = r_wr_en;
  assign wr_address = r_wr_address;
  assign wr_data    = r_wr_data;
  assign busy       = (r_state == ST_GRANT);
  assign last_owner = r_last_owner;

endmodule
`default_nettype wire
